// File: rtl/sparc_mem_pkg.sv
// Shared definitions for the SPARC RAM responder: op3 codes, FSM state
// encoding and the op3 size decode.
package sparc_mem_pkg;

  localparam logic [5:0] OP_LD   = 6'b000000;
  localparam logic [5:0] OP_LDUB = 6'b000001;
  localparam logic [5:0] OP_LDUH = 6'b000010;
  localparam logic [5:0] OP_ST   = 6'b000100;
  localparam logic [5:0] OP_STB  = 6'b000101;
  localparam logic [5:0] OP_STH  = 6'b000110;
  localparam logic [5:0] OP_LDSB = 6'b001001;
  localparam logic [5:0] OP_LDSH = 6'b001010;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILLEGAL} size_t;

  function automatic size_t size_decode(input logic [5:0] op3);
    case (op3)
      OP_LDUB, OP_STB, OP_LDSB: return SZ_BYTE;
      OP_LDUH, OP_STH, OP_LDSH: return SZ_HALF;
      OP_LD, OP_ST:             return SZ_WORD;
      default:                  return SZ_ILLEGAL;
    endcase
  endfunction

  function automatic logic is_store(input logic [5:0] op3);
    return (op3 == OP_ST) || (op3 == OP_STB) || (op3 == OP_STH);
  endfunction

endpackage

// File: rtl/ram_byte_array.sv
// Byte-wide storage with a 4-byte big-endian window at addr.
// Lane 3 is the byte at addr (most significant), lane 0 is addr+3.
module ram_byte_array #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        we,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [7:0] mem [DEPTH];

  logic [ADDR_W-1:0] a0, a1, a2, a3;

  assign a0 = addr;
  assign a1 = addr + ADDR_W'(1);
  assign a2 = addr + ADDR_W'(2);
  assign a3 = addr + ADDR_W'(3);

  // Per-lane byte writes; storage has no reset so contents survive RESET.
  always_ff @(posedge clk) begin
    if (we[3]) mem[a0] <= wdata[31:24];
    if (we[2]) mem[a1] <= wdata[23:16];
    if (we[1]) mem[a2] <= wdata[15:8];
    if (we[0]) mem[a3] <= wdata[7:0];
  end

  assign rdata = {mem[a0], mem[a1], mem[a2], mem[a3]};

endmodule

// File: rtl/sparc_ram_responder.sv
// RAM handshake responder: captures a load/store on RAM_enable, executes it
// after LATENCY cycles, then holds MFC (and fault) until enable is released.
module sparc_ram_responder
  import sparc_mem_pkg::*;
#(
  parameter int ADDR_W  = 9,
  parameter int LATENCY = 2
) (
  input  logic              Clk,
  input  logic              RESET,
  input  logic              RAM_enable,
  input  logic [5:0]        RAM_OpCode,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  output logic              MFC,
  output logic              fault
);

  state_t            state;
  logic [3:0]        cnt;
  logic [5:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       din_q;

  size_t             size_q;
  logic              fault_c;
  logic              exec;
  logic [3:0]        we;
  logic [31:0]       wdata;
  logic [31:0]       rdata;

  // Zero/sign extension of the big-endian window for the captured load op.
  function automatic logic [31:0] load_extend(input logic [5:0] op3,
                                              input logic [31:0] win);
    case (op3)
      OP_LDUB: return {24'd0, win[31:24]};
      OP_LDSB: return {{24{win[31]}}, win[31:24]};
      OP_LDUH: return {16'd0, win[31:16]};
      OP_LDSH: return {{16{win[31]}}, win[31:16]};
      default: return win;
    endcase
  endfunction

  assign size_q  = size_decode(op_q);
  assign fault_c = (size_q == SZ_ILLEGAL) ||
                   ((size_q == SZ_HALF) && addr_q[0]) ||
                   ((size_q == SZ_WORD) && (addr_q[1:0] != 2'b00));
  // Completion edge: last BUSY cycle with the request still held.
  assign exec    = (state == ST_BUSY) && RAM_enable && (cnt == 4'd0);

  // Lane enables and left-justified store data for the array write port.
  always_comb begin
    we    = 4'b0000;
    wdata = din_q;
    if (exec && !fault_c && is_store(op_q)) begin
      case (size_q)
        SZ_BYTE: begin we = 4'b1000; wdata = {din_q[7:0], 24'd0};  end
        SZ_HALF: begin we = 4'b1100; wdata = {din_q[15:0], 16'd0}; end
        SZ_WORD: begin we = 4'b1111; wdata = din_q;                end
        default: begin we = 4'b0000; wdata = din_q;                end
      endcase
    end
  end

  ram_byte_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (Clk),
    .addr  (addr_q),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata)
  );

  // Request capture: operands are sampled only on the accepting edge.
  always_ff @(posedge Clk) begin
    if ((state == ST_IDLE) && RAM_enable) begin
      op_q   <= RAM_OpCode;
      addr_q <= address;
      din_q  <= data_in;
    end
  end

  // Handshake FSM with registered MFC, fault and load result.
  always_ff @(posedge Clk or posedge RESET) begin
    if (RESET) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      MFC      <= 1'b0;
      fault    <= 1'b0;
      data_out <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (RAM_enable) begin
            cnt   <= 4'(LATENCY - 1);
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (!RAM_enable) begin
            state <= ST_IDLE;
          end else if (cnt == 4'd0) begin
            state <= ST_DONE;
            MFC   <= 1'b1;
            fault <= fault_c;
            if (!fault_c && !is_store(op_q))
              data_out <= load_extend(op_q, rdata);
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_DONE: begin
          if (!RAM_enable) begin
            state <= ST_IDLE;
            MFC   <= 1'b0;
            fault <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sparc_ram_responder.sv
// Scoreboard bench for sparc_ram_responder: a byte-array reference model
// predicts each completion; a monitor compares on every MFC rising edge.
module tb_sparc_ram_responder;

  localparam int ADDR_W  = 9;
  localparam int LATENCY = 2;
  localparam int DEPTH   = 1 << ADDR_W;

  localparam logic [5:0] LD   = 6'b000000;
  localparam logic [5:0] LDUB = 6'b000001;
  localparam logic [5:0] LDUH = 6'b000010;
  localparam logic [5:0] ST   = 6'b000100;
  localparam logic [5:0] STB  = 6'b000101;
  localparam logic [5:0] STH  = 6'b000110;
  localparam logic [5:0] LDSB = 6'b001001;
  localparam logic [5:0] LDSH = 6'b001010;

  logic              Clk = 1'b0;
  logic              RESET = 1'b1;
  logic              RAM_enable = 1'b0;
  logic [5:0]        RAM_OpCode = '0;
  logic [ADDR_W-1:0] address = '0;
  logic [31:0]       data_in = '0;
  logic [31:0]       data_out;
  logic              MFC;
  logic              fault;

  sparc_ram_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
    .Clk        (Clk),
    .RESET      (RESET),
    .RAM_enable (RAM_enable),
    .RAM_OpCode (RAM_OpCode),
    .address    (address),
    .data_in    (data_in),
    .data_out   (data_out),
    .MFC        (MFC),
    .fault      (fault)
  );

  always #5 Clk = ~Clk;

  int edge_cnt = 0;
  always @(posedge Clk) edge_cnt++;

  typedef struct {
    int          cap;
    bit          flt;
    logic [31:0] dout;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  logic [7:0]  ref_mem [DEPTH];
  logic [31:0] ref_dout = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, req);
  endtask

  // Reference model: applies the access rules directly to a byte array.
  task automatic ref_access(input logic [5:0] op, input int a, input logic [31:0] d,
                            output bit f);
    int     sz;
    bit     st, sgn, bad;
    longint v;
    sz = 0; st = 0; sgn = 0; bad = 0;
    case (op)
      LD:   sz = 4;
      LDUB: sz = 1;
      LDUH: sz = 2;
      ST:   begin sz = 4; st = 1; end
      STB:  begin sz = 1; st = 1; end
      STH:  begin sz = 2; st = 1; end
      LDSB: begin sz = 1; sgn = 1; end
      LDSH: begin sz = 2; sgn = 1; end
      default: bad = 1;
    endcase
    f = bad || ((a % sz) != 0);
    if (f) return;
    if (st) begin
      for (int k = 0; k < sz; k++)
        ref_mem[a + k] = 8'((d >> (8 * (sz - 1 - k))) & 32'hFF);
    end else begin
      v = 0;
      for (int k = 0; k < sz; k++) v = v * 256 + longint'(ref_mem[a + k]);
      if (sgn && v >= (longint'(1) << (8 * sz - 1))) v = v - (longint'(1) << (8 * sz));
      ref_dout = 32'(v);
    end
  endtask

  // One handshake; abort drops enable during BUSY, hold_done leaves DONE held.
  task automatic access(input logic [5:0] op, input int a, input logic [31:0] d,
                        input bit abort, input bit hold_done);
    bit   f, got;
    exp_t e;
    @(negedge Clk);
    RAM_OpCode = op; address = ADDR_W'(a); data_in = d; RAM_enable = 1'b1;
    if (abort) begin
      @(negedge Clk);
      RAM_enable = 1'b0;
      address = ADDR_W'($urandom);
      repeat (LATENCY + 3) begin
        @(negedge Clk);
        chk("abort_no_mfc", 32'(MFC), 32'd0);
      end
      return;
    end
    ref_access(op, a, d, f);
    e.cap = edge_cnt + 1; e.flt = f; e.dout = ref_dout;
    exp_q.push_back(e);
    @(negedge Clk);
    RAM_OpCode = 6'($urandom); address = ADDR_W'($urandom); data_in = $urandom;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (MFC) got = 1;
      else @(negedge Clk);
    end
    if (!got) begin
      n_chk++;
      $display("FAIL mfc_timeout actual=MFC low after 20 cycles required=MFC high op=%b addr=%0h", op, a);
      void'(exp_q.pop_back());
      RAM_enable = 1'b0;
      return;
    end
    if (hold_done) return;
    repeat ($urandom_range(0, 2)) begin
      @(negedge Clk);
      chk("mfc_hold", 32'(MFC), 32'd1);
    end
    RAM_enable = 1'b0;
    @(posedge Clk); #1;
    chk("mfc_fall", 32'(MFC), 32'd0);
    chk("fault_fall", 32'(fault), 32'd0);
  endtask

  // Monitor: every MFC rising edge must match the oldest expected completion.
  bit mfc_prev = 1'b0;
  always @(negedge Clk) begin
    exp_t e;
    if (MFC && !mfc_prev) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_mfc actual=MFC rose required=no pending request");
      end else begin
        e = exp_q.pop_front();
        chk("latency", 32'(edge_cnt - e.cap), 32'(LATENCY));
        chk("fault", 32'(fault), 32'(e.flt));
        chk("data_out", data_out, e.dout);
      end
    end
    mfc_prev = MFC;
  end

  initial begin
    logic [5:0] op;
    int         a;
    bit         ab;
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = 8'($urandom);
      dut.u_array.mem[i] = ref_mem[i];
    end
    repeat (2) @(negedge Clk);
    chk("rst_mfc", 32'(MFC), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_data_out", data_out, 32'd0);
    RESET = 1'b0;

    // Word store/load round trip.
    access(ST, 'h010, 32'hDEADBEEF, 0, 0);
    access(LD, 'h010, 32'h0, 0, 0);
    chk("ld_word", data_out, 32'hDEADBEEF);

    // Byte store with signed and unsigned reloads.
    access(STB, 'h021, 32'h12345680, 0, 0);
    access(LDSB, 'h021, 32'h0, 0, 0);
    chk("ldsb", data_out, 32'hFFFFFF80);
    access(LDUB, 'h021, 32'h0, 0, 0);
    chk("ldub", data_out, 32'h00000080);

    // Halfword store into a preloaded word.
    for (int i = 'h030; i < 'h034; i++) begin
      ref_mem[i] = 8'hAA;
      dut.u_array.mem[i] = 8'hAA;
    end
    access(STH, 'h030, 32'hFFFF1234, 0, 0);
    access(LD, 'h030, 32'h0, 0, 0);
    chk("ld_after_sth", data_out, 32'h1234AAAA);

    // Misaligned and illegal ops fault without side effects.
    access(LD, 'h012, 32'h0, 0, 0);
    access(LDUH, 'h013, 32'h0, 0, 0);
    access(6'b111111, 'h010, 32'h55555555, 0, 0);
    chk("fault_keeps_dout", data_out, 32'h1234AAAA);
    access(LD, 'h010, 32'h0, 0, 0);
    chk("fault_no_write", data_out, 32'hDEADBEEF);

    // Aborted store leaves the array alone.
    access(ST, 'h040, 32'h11111111, 0, 0);
    access(ST, 'h040, 32'h99999999, 1, 0);
    access(LD, 'h040, 32'h0, 0, 0);
    chk("abort_no_write", data_out, 32'h11111111);

    // Asynchronous reset while in DONE.
    access(ST, 'h050, 32'hCAFEF00D, 0, 0);
    access(LD, 'h050, 32'h0, 0, 1);
    #2 RESET = 1'b1;
    #1;
    chk("rst_done_mfc", 32'(MFC), 32'd0);
    chk("rst_done_fault", 32'(fault), 32'd0);
    chk("rst_done_dout", data_out, 32'd0);
    ref_dout = 32'd0;
    @(negedge Clk);
    RESET = 1'b0; RAM_enable = 1'b0;
    @(negedge Clk);
    access(LD, 'h050, 32'h0, 0, 0);
    chk("array_kept", data_out, 32'hCAFEF00D);

    // Randomized traffic against the model.
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 8))
        0: op = LD;   1: op = LDUB; 2: op = LDUH; 3: op = ST;
        4: op = STB;  5: op = STH;  6: op = LDSB; 7: op = LDSH;
        default: begin
          op = 6'($urandom_range(0, 63));
          if (op inside {LD, LDUB, LDUH, ST, STB, STH, LDSB, LDSH}) op = 6'b111111;
        end
      endcase
      a = int'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 3) != 0) a = a & ~3;
      ab = ($urandom_range(0, 9) == 0);
      access(op, a, $urandom, ab, 0);
    end

    repeat (4) @(negedge Clk);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sparc_ram_responder.md
# sparc_ram_responder

Memory-side responder for the SPARC V8 datapath's RAM handshake. The control unit initiates an access by raising `RAM_enable` with a load/store op3 code. This block performs the byte, halfword or word access on a 512-byte big-endian array after a fixed latency, then asserts `MFC` until the initiator releases `RAM_enable`. It sits between the datapath's MAR/MDR and the control unit's wait-for-MFC states. It also flags misaligned and illegal accesses so the control unit can raise a trap.

## Interface
- `ADDR_W`, 9: byte-address width; array depth is 2^ADDR_W bytes.
- `LATENCY`, 2: cycles from request capture to completion; legal range 1..15.

- `Clk` in 1: single clock, rising-edge.
- `RESET` in 1: asynchronous, active-high reset.
- `RAM_enable` in 1: request; held high by initiator until `MFC` seen.
- `RAM_OpCode` in 6: SPARC op3 code. LD 000000, LDUB 000001, LDUH 000010, ST 000100, STB 000101, STH 000110, LDSB 001001, LDSH 001010.
- `address` in ADDR_W: byte address from MAR.
- `data_in` in 32: store data from MDR; bytes/halfwords come from the low bits.
- `data_out` out 32: load result, zero- or sign-extended, registered.
- `MFC` out 1: memory function complete.
- `fault` out 1: access rejected (misaligned or illegal op3); valid while `MFC`=1.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - `RAM_enable`=1 at a rising edge captures `RAM_OpCode`, `address` and `data_in`.
  - Loads the latency counter with LATENCY-1 and moves to BUSY.
- BUSY:
  - Counter decrements each cycle.
  - At count 0 the access executes and the FSM moves to DONE.
  - If `RAM_enable` is 0 during any BUSY cycle, the request aborts: return to IDLE, no array write, outputs unchanged.
- DONE:
  - `MFC`=1 and `fault` is valid.
  - The FSM stays in DONE while `RAM_enable`=1.
  - `RAM_enable`=0 returns the FSM to IDLE and clears `MFC` and `fault`.
  - A new request needs at least one IDLE cycle, i.e. enable low for at least one edge.
- Byte order is big-endian. Word at address A is {mem[A], mem[A+1], mem[A+2], mem[A+3]}; halfword is {mem[A], mem[A+1]}.
- Stores:
  - STB writes `data_in[7:0]`.
  - STH writes `data_in[15:0]`.
  - ST writes all 32 bits.
  - `data_out` is unchanged by any store.
- Loads:
  - LDUB and LDUH zero-extend.
  - LDSB and LDSH sign-extend from bit 7 and bit 15 respectively.
  - LD returns the full word.
- Fault conditions:
  - Halfword op with `address[0]`=1.
  - Word op with `address[1:0]`≠00.
  - Any op3 not in the list above.
  - On fault: no array write, `data_out` unchanged, `fault`=1 with `MFC`=1 after normal latency.
- Addresses use the low ADDR_W bits. Word/halfword byte offsets never wrap, because aligned accesses cannot cross the top of the array.

## Timing
- Reset values:
  - State IDLE.
  - `MFC`=0, `fault`=0, `data_out`=0, counter 0.
  - Array contents are NOT cleared by `RESET`.
- Latency: request captured at edge E0. `MFC` rises after edge E0+LATENCY, and `data_out` is valid in the same cycle.
- `MFC` falls the cycle after `RAM_enable` is sampled low in DONE.
- `RESET` asserted mid-access (BUSY or DONE) returns the FSM to IDLE immediately. A pending store is discarded. A store in the completing cycle is committed only if that edge precedes reset assertion.
- Inputs are sampled only at the capture edge. Changes to `address`, `data_in` or `RAM_OpCode` during BUSY/DONE have no effect.

## Structure
- Shared package `sparc_mem_pkg` holds:
  - op3 constants (OP_LD, OP_LDUB, OP_LDUH, OP_ST, OP_STB, OP_STH, OP_LDSB, OP_LDSH);
  - the FSM state encoding;
  - a size-decode function mapping op3 to {byte, half, word, illegal}.
- Sub-module `ram_byte_array`:
  - 2^ADDR_W×8 storage with four byte-lane write enables and a 4-byte big-endian read port.
  - Alignment, extension and the FSM stay in the top level.
- Benches preload the array hierarchically, as existing datapath tests do.

## Test plan
- ST 0xDEADBEEF @0x010, then LD @0x010 → `data_out`=0xDEADBEEF; `MFC` rises exactly LATENCY edges after each capture.
- STB 0x80 @0x021, then LDSB @0x021 → 0xFFFFFF80; LDUB @0x021 → 0x00000080.
- STH 0x1234 @0x030 (preloaded 0xAAAAAAAA), then LD @0x030 → 0x1234AAAA.
- LD @0x012, LDUH @0x013, and op3 111111 → `fault`=1 with `MFC`=1 each time; array and `data_out` unchanged.
- ST @0x040 with `RAM_enable` dropped in BUSY → no `MFC`; subsequent LD @0x040 returns the prior value.
- `RESET` pulsed while in DONE → `MFC`=0 and `data_out`=0 immediately; array contents retained (LD returns the prior store).
